space_wire_pulse_sync_multi: RTL and testbench

- Multi-channel, lossless pulse synchronizer. Carries single-cycle event pulses from the SpaceWire receive clock domain (i_async_clk) into the system clock domain (i_clk).
- Each channel uses a toggle request/acknowledge handshake.
- A per-channel pending counter accumulates pulses that arrive while a transfer is in flight, so back-to-back events are delivered rather than merged.
- Sits between the receiver's code/time-code detectors and the link FSM / host interface.

---
 rtl/space_wire_pulse_sync_multi.sv | 101 ++++++++++
 tb/tb_space_wire_pulse_sync_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/space_wire_pulse_sync_multi.sv
// Multi-channel lossless pulse synchronizer: i_async_clk events -> i_clk pulses via toggle req/ack.
// Optional sticky overflow flags enabled by SPW_PULSE_SYNC_OVF_FLAG_EN.
`timescale 1ns/1ps
module space_wire_pulse_sync_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 3
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_async_clk,
  input  logic [NUM_CH-1:0] i_async_pulse,
  input  logic              i_async_ovf_clr,
  output logic [NUM_CH-1:0] o_async_busy,
  output logic [NUM_CH-1:0] o_async_overflow,
  output logic [NUM_CH-1:0] o_sync_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [NUM_CH-1:0] w_drop;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0]       r_pend_cnt;
    logic                   r_req_tgl;
    logic                   r_ack_seen;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_edge;
    logic                   r_pulse;
    logic                   w_wait;
    logic                   w_launch;
    logic                   w_full;
    logic                   w_inc;

    assign w_wait     = r_req_tgl != r_ack_seen;
    assign w_launch   = !w_wait && (r_pend_cnt != '0);
    assign w_full     = r_pend_cnt == CNT_MAX;
    assign w_inc      = i_async_pulse[ch];
    assign w_drop[ch] = w_inc && w_full && !w_launch;

    // Source domain: pending counter plus toggle request, closed by the returned ack.
    always_ff @(posedge i_async_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_pend_cnt <= '0;
        r_req_tgl  <= 1'b0;
        r_ack_seen <= 1'b0;
        r_ack_sync <= '0;
      end else begin
        if (w_launch && !w_inc)
          r_pend_cnt <= r_pend_cnt - CNT_ONE;
        else if (!w_launch && w_inc && !w_full)
          r_pend_cnt <= r_pend_cnt + CNT_ONE;
        if (w_launch)
          r_req_tgl <= ~r_req_tgl;
        r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_edge};
        if (w_wait && (r_ack_sync[SYNC_STAGES-1] == r_req_tgl))
          r_ack_seen <= r_req_tgl;
      end
    end

    // Destination domain: the edge flop doubles as the ack toggle sent back.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_req_sync <= '0;
        r_edge     <= 1'b0;
        r_pulse    <= 1'b0;
      end else begin
        r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req_tgl};
        r_edge     <= r_req_sync[SYNC_STAGES-1];
        r_pulse    <= r_req_sync[SYNC_STAGES-1] ^ r_edge;
      end
    end

    assign o_sync_pulse[ch] = r_pulse;
    assign o_async_busy[ch] = (r_pend_cnt != '0) | w_wait;

`ifdef SPW_PULSE_SYNC_OVF_FLAG_EN
    logic r_ovf;
    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_async_clk or negedge i_reset_n) begin
      if (!i_reset_n)
        r_ovf <= 1'b0;
      else if (w_drop[ch])
        r_ovf <= 1'b1;
      else if (i_async_ovf_clr)
        r_ovf <= 1'b0;
    end
    assign o_async_overflow[ch] = r_ovf;
`else
    assign o_async_overflow[ch] = 1'b0;
`endif
  end

`ifndef SPW_PULSE_SYNC_OVF_FLAG_EN
  logic w_unused_ovf;
  assign w_unused_ovf = i_async_ovf_clr ^ (|w_drop);
`endif

endmodule

// File: tb/tb_space_wire_pulse_sync_multi.sv
// Directed bench for space_wire_pulse_sync_multi: latency, bursts, saturation, reset, random bursts.
`timescale 1ns/1ps
module tb_space_wire_pulse_sync_multi;
  localparam int NUM_CH = 4;

  logic              i_clk = 1'b0;
  logic              i_async_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [NUM_CH-1:0] i_async_pulse = '0;
  logic              i_async_ovf_clr = 1'b0;
  logic [NUM_CH-1:0] o_async_busy;
  logic [NUM_CH-1:0] o_async_overflow;
  logic [NUM_CH-1:0] o_sync_pulse;

  space_wire_pulse_sync_multi #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .CNT_W(3)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_async_clk(i_async_clk),
    .i_async_pulse(i_async_pulse), .i_async_ovf_clr(i_async_ovf_clr),
    .o_async_busy(o_async_busy), .o_async_overflow(o_async_overflow),
    .o_sync_pulse(o_sync_pulse)
  );

  // Even half-periods: i_clk edges land on even times, i_async_clk edges on odd times.
  int chalf = 4;
  int ahalf = 40;
  initial forever #(chalf) i_clk = ~i_clk;
  initial begin #1; forever #(ahalf) i_async_clk = ~i_async_clk; end

  int checks = 0;
  int errors = 0;
  int dcnt[NUM_CH] = '{default:0};
  int last_cyc[NUM_CH] = '{default:0};
  int base[NUM_CH];
  int cyc = 0;
  int wide_err = 0;
  logic [NUM_CH-1:0] prev_p = '0;

  always @(negedge i_clk) begin
    cyc++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (o_sync_pulse[c]) begin
        dcnt[c]++;
        last_cyc[c] = cyc;
        if (prev_p[c]) wide_err++;
      end
    end
    prev_p = o_sync_pulse;
  end

  task automatic drive(input logic [NUM_CH-1:0] m, input int n);
    repeat (n) begin
      @(negedge i_async_clk);
      i_async_pulse = m;
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (o_async_busy !== '0 && k < 5000) begin
      @(negedge i_async_clk);
      k++;
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_async_busy !== '0) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%b expected 0000", name, o_async_busy);
    end
  endtask

  task automatic check_delta(input string name, input int e0, input int e1, input int e2, input int e3);
    int exp_d[NUM_CH];
    exp_d = '{e0, e1, e2, e3};
    for (int c = 0; c < NUM_CH; c++) begin
      checks++;
      if ((dcnt[c] - base[c]) !== exp_d[c]) begin
        errors++;
        $display("FAIL %s ch%0d delivered: got %0d expected %0d", name, c, dcnt[c] - base[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks += 3;
    if (o_sync_pulse !== '0) begin errors++; $display("FAIL reset_pulse: got %b expected 0000", o_sync_pulse); end
    if (o_async_busy !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", o_async_busy); end
    if (o_async_overflow !== '0) begin errors++; $display("FAIL reset_ovf: got %b expected 0000", o_async_overflow); end
    @(negedge i_clk); #2;
    i_reset_n = 1'b1;
    repeat (4) @(negedge i_async_clk);
  endtask

  task automatic test_single();
    int n = 0;
    base = dcnt;
    @(negedge i_async_clk); i_async_pulse = 4'b0001;
    @(negedge i_async_clk); i_async_pulse = '0;
    checks++;
    if (o_async_busy !== 4'b0001) begin errors++; $display("FAIL single_busy: got %b expected 0001", o_async_busy); end
    @(posedge i_async_clk);  // launch edge: req toggles here
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (!o_sync_pulse[0] && n < 20);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL single_latency: got %0d i_clk cycles expected 3", n); end
    wait_idle("single");
    check_delta("single", 1, 0, 0, 0);
  endtask

  task automatic test_burst5();
    base = dcnt;
    drive(4'b0010, 5);
    drive('0, 1);
    wait_idle("burst5");
    check_delta("burst5", 0, 5, 0, 0);
    checks++;
    if (o_async_overflow !== '0) begin errors++; $display("FAIL burst5_ovf: got %b expected 0000", o_async_overflow); end
  endtask

  task automatic test_burst10();
    logic [NUM_CH-1:0] exp_ovf;
`ifdef SPW_PULSE_SYNC_OVF_FLAG_EN
    exp_ovf = 4'b0100;
`else
    exp_ovf = 4'b0000;
`endif
    chalf = 20; ahalf = 2;
    repeat (4) @(negedge i_clk);
    base = dcnt;
    drive(4'b0100, 10);
    drive('0, 1);
    checks++;
    if (o_async_overflow !== exp_ovf) begin errors++; $display("FAIL burst10_ovf_set: got %b expected %b", o_async_overflow, exp_ovf); end
    wait_idle("burst10");
    check_delta("burst10", 0, 0, 8, 0);
    checks++;
    if (o_async_overflow !== exp_ovf) begin errors++; $display("FAIL burst10_ovf_hold: got %b expected %b", o_async_overflow, exp_ovf); end
    @(negedge i_async_clk); i_async_ovf_clr = 1'b1;
    @(negedge i_async_clk); i_async_ovf_clr = 1'b0;
    checks++;
    if (o_async_overflow !== '0) begin errors++; $display("FAIL burst10_ovf_clr: got %b expected 0000", o_async_overflow); end
    chalf = 4; ahalf = 40;
    repeat (4) @(negedge i_async_clk);
  endtask

  task automatic test_simul();
    base = dcnt;
    drive(4'b1111, 1);
    drive(4'b1000, 1);  // ch3 increments on its own launch cycle
    drive('0, 1);
    wait_idle("simul");
    check_delta("simul", 1, 1, 1, 2);
    checks++;
    if (last_cyc[0] !== last_cyc[1] || last_cyc[1] !== last_cyc[2]) begin
      errors++;
      $display("FAIL simul_align: cycles %0d %0d %0d expected equal", last_cyc[0], last_cyc[1], last_cyc[2]);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'b0001, 4);  // ch0: one in flight, pend_cnt reaches 3
    drive('0, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    base = dcnt;
    checks += 2;
    if (o_async_busy !== '0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0000", o_async_busy); end
    if (o_sync_pulse !== '0) begin errors++; $display("FAIL rstmid_pulse: got %b expected 0000", o_sync_pulse); end
    repeat (3) @(negedge i_async_clk);
    @(negedge i_clk); #2;
    i_reset_n = 1'b1;
    repeat (10) @(negedge i_async_clk);
    check_delta("rstmid_quiet", 0, 0, 0, 0);
    checks++;
    if (o_async_busy !== '0) begin errors++; $display("FAIL rstmid_busy_after: got %b expected 0000", o_async_busy); end
    base = dcnt;
    drive(4'b0001, 1);
    drive('0, 1);
    wait_idle("rstmid_new");
    check_delta("rstmid_new", 1, 0, 0, 0);
  endtask

  task automatic test_random();
    int inj[NUM_CH];
    int n;
    logic [NUM_CH-1:0] m;
    for (int r = 0; r < 20; r++) begin
      chalf = 2 * int'($urandom_range(1, 7));
      ahalf = 2 * int'($urandom_range(1, 7));
      repeat (3) @(negedge i_clk);
      repeat (3) @(negedge i_async_clk);
      base = dcnt;
      inj = '{default:0};
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        m = NUM_CH'($urandom_range(0, 15));
        for (int c = 0; c < NUM_CH; c++) inj[c] += int'(m[c]);
        drive(m, 1);
      end
      drive('0, 1);
      wait_idle("random");
      for (int c = 0; c < NUM_CH; c++) begin
        checks++;
        if ((dcnt[c] - base[c]) !== inj[c]) begin
          errors++;
          $display("FAIL random r%0d ch%0d: delivered %0d expected %0d", r, c, dcnt[c] - base[c], inj[c]);
        end
      end
    end
    checks++;
    if (wide_err !== 0) begin errors++; $display("FAIL pulse_width: %0d wide pulses expected 0", wide_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst5();
    test_burst10();
    test_simul();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
